// File: rtl/hash_feeder_pkg.sv
// Shared types and widths for the hash core message feeder.
// Holds the FSM state encoding and a counter-width helper.
package hash_feeder_pkg;

  localparam int unsigned DIGEST_W = 32;
  localparam int unsigned CNT_W    = 64;
  localparam int unsigned BYTE_W   = 8;

  typedef enum logic [2:0] {
    LOAD,
    SEND,
    GAP,
    WAIT_DIG,
    OUT
  } feeder_state_t;

  // Bits needed to hold 0..max_val inclusive, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/msg_byte_buffer.sv
// Message byte store: synchronous write, combinational read.
// Addresses at or beyond DEPTH are ignored on write and read as zero.
module msg_byte_buffer
  import hash_feeder_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [BYTE_W-1:0] rd_data
);

  localparam int unsigned       IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; every byte is written before it is read back.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < DEPTH_A)) begin
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  assign rd_data = (rd_addr < DEPTH_A) ? mem[rd_addr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/hash_msg_feeder.sv
// Buffers one host message, replays it byte-serially into a hash core,
// waits for the digest-ready edge and hands the digest back to the host.
module hash_msg_feeder
  import hash_feeder_pkg::*;
#(
  parameter int unsigned MAX_LEN  = 64,
  parameter int unsigned BYTE_GAP = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  input  logic [BYTE_W-1:0]   s_data,
  input  logic                s_last,
  output logic                s_ready,
  output logic                m_valid,
  output logic [BYTE_W-1:0]   m_message,
  output logic [CNT_W-1:0]    m_counter,
  input  logic                hash_ready,
  input  logic [DIGEST_W-1:0] digest_in,
  output logic                d_valid,
  output logic [DIGEST_W-1:0] d_digest,
  input  logic                d_ready,
  output logic                err_overflow,
  output logic                err_timeout
);

  localparam int unsigned PTR_W = cnt_width(MAX_LEN);
  localparam int unsigned GAP_W = cnt_width(BYTE_GAP);
  localparam int unsigned TO_W  = cnt_width(TIMEOUT);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(MAX_LEN);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BYTE_GAP - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  feeder_state_t       state, state_d;
  logic [PTR_W-1:0]    wr_ptr, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr, rd_ptr_d;
  logic [PTR_W-1:0]    len, len_d;
  logic [GAP_W-1:0]    gap_cnt, gap_cnt_d;
  logic [TO_W-1:0]     to_cnt, to_cnt_d;
  logic                hr_q, hr_d;
  logic [DIGEST_W-1:0] d_digest_d;
  logic [BYTE_W-1:0]   m_message_d;
  logic [BYTE_W-1:0]   rd_data;
  logic                wr_en;
  logic                ovf_d, to_d;
  logic                s_ready_d, m_valid_d, d_valid_d;

  msg_byte_buffer #(
    .DEPTH  (MAX_LEN),
    .ADDR_W (PTR_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (s_data),
    .rd_addr (rd_ptr_d),
    .rd_data (rd_data)
  );

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_d    = state;
    wr_ptr_d   = wr_ptr;
    rd_ptr_d   = rd_ptr;
    len_d      = len;
    gap_cnt_d  = gap_cnt;
    to_cnt_d   = to_cnt;
    hr_d       = hr_q;
    d_digest_d = d_digest;
    wr_en      = 1'b0;
    ovf_d      = 1'b0;
    to_d       = 1'b0;

    unique case (state)
      LOAD: begin
        if (s_valid && s_ready) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr + PTR_ONE;
          if (s_last || (wr_ptr == PTR_LAST)) begin
            len_d   = wr_ptr + PTR_ONE;
            state_d = SEND;
            ovf_d   = !s_last;
          end
        end
      end
      SEND: begin
        rd_ptr_d  = rd_ptr + PTR_ONE;
        gap_cnt_d = '0;
        if (rd_ptr == (len - PTR_ONE)) begin
          // Sample the level on entry so a digest-ready left high by the core is not an edge.
          state_d  = WAIT_DIG;
          to_cnt_d = '0;
          hr_d     = hash_ready;
        end else if (BYTE_GAP == 0) begin
          state_d = SEND;
        end else begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = SEND;
        end else begin
          gap_cnt_d = gap_cnt + GAP_W'(1);
        end
      end
      WAIT_DIG: begin
        hr_d     = hash_ready;
        to_cnt_d = to_cnt + TO_W'(1);
        if (hash_ready && !hr_q) begin
          d_digest_d = digest_in;
          to_cnt_d   = '0;
          state_d    = OUT;
        end else if (to_cnt == TO_LAST) begin
          to_d     = 1'b1;
          to_cnt_d = '0;
          hr_d     = 1'b0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          len_d    = '0;
          state_d  = LOAD;
        end
      end
      OUT: begin
        if (d_valid && d_ready) begin
          hr_d     = 1'b0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          len_d    = '0;
          state_d  = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Registered outputs are loaded from next-state values so they line up with the state.
  always_comb begin
    s_ready_d   = (state_d == LOAD) && (wr_ptr_d < PTR_MAX);
    m_valid_d   = (state_d == SEND);
    d_valid_d   = (state_d == OUT);
    m_message_d = m_message;
    if (state_d == SEND) begin
      // A one-byte message is still being written into the buffer on this edge.
      m_message_d = (wr_en && (wr_ptr == rd_ptr_d)) ? s_data : rd_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      len          <= '0;
      gap_cnt      <= '0;
      to_cnt       <= '0;
      hr_q         <= 1'b0;
      s_ready      <= 1'b1;
      m_valid      <= 1'b0;
      m_message    <= '0;
      d_valid      <= 1'b0;
      d_digest     <= '0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_d;
      wr_ptr       <= wr_ptr_d;
      rd_ptr       <= rd_ptr_d;
      len          <= len_d;
      gap_cnt      <= gap_cnt_d;
      to_cnt       <= to_cnt_d;
      hr_q         <= hr_d;
      s_ready      <= s_ready_d;
      m_valid      <= m_valid_d;
      m_message    <= m_message_d;
      d_valid      <= d_valid_d;
      d_digest     <= d_digest_d;
      err_overflow <= ovf_d;
      err_timeout  <= to_d;
    end
  end

  assign m_counter = CNT_W'(len);

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Randomised bench for hash_msg_feeder: a host driver, a simple hash-core
// responder and a cycle-stamped monitor checked against message-level rules.
module tb_hash_msg_feeder;

  localparam int MAX_LEN  = 8;
  localparam int BYTE_GAP = 2;
  localparam int TIMEOUT  = 16;
  localparam int PERIOD   = 1 + BYTE_GAP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        m_valid;
  logic [7:0]  m_message;
  logic [63:0] m_counter;
  logic        hash_ready = 1'b0;
  logic [31:0] digest_in = '0;
  logic        d_valid;
  logic [31:0] d_digest;
  logic        d_ready = 1'b0;
  logic        err_overflow;
  logic        err_timeout;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;

  int          mv_cyc[$];
  logic [7:0]  mv_byte[$];
  logic [63:0] mv_cnt[$];
  int          ovf_cyc[$];
  int          to_cyc[$];
  int          dv_cnt = 0;
  logic [7:0]  tx[$];

  hash_msg_feeder #(
    .MAX_LEN  (MAX_LEN),
    .BYTE_GAP (BYTE_GAP),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .m_valid      (m_valid),
    .m_message    (m_message),
    .m_counter    (m_counter),
    .hash_ready   (hash_ready),
    .digest_in    (digest_in),
    .d_valid      (d_valid),
    .d_digest     (d_digest),
    .d_ready      (d_ready),
    .err_overflow (err_overflow),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid) begin
        mv_cyc.push_back(cyc);
        mv_byte.push_back(m_message);
        mv_cnt.push_back(m_counter);
      end
      if (err_overflow) ovf_cyc.push_back(cyc);
      if (err_timeout)  to_cyc.push_back(cyc);
      if (d_valid)      dv_cnt = dv_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mv_cyc.delete();
    mv_byte.delete();
    mv_cnt.delete();
    ovf_cyc.delete();
    to_cyc.delete();
    dv_cnt = 0;
  endtask

  task automatic make_msg(input int n);
    tx.delete();
    for (int i = 0; i < n; i++) tx.push_back(8'($urandom));
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  // Presents tx on the host port; idle cycles inserted at random when allowed.
  task automatic host_send(input bit with_last, input bit allow_idle,
                           output int n_acc, output int last_acc);
    int idx   = 0;
    int stall = 0;
    n_acc    = 0;
    last_acc = -1;
    while (idx < tx.size() && stall < 6) begin
      tick();
      if (allow_idle && ($urandom_range(0, 3) == 0)) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = tx[idx];
        s_last  = with_last && (idx == tx.size() - 1);
        if (s_ready) begin
          n_acc++;
          last_acc = cyc;
          idx++;
        end else begin
          stall++;
        end
      end
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_pulses(input int n, input int first);
    check("pulse_count", mv_cyc.size(), n);
    for (int i = 0; i < n && i < mv_cyc.size(); i++) begin
      check("pulse_cycle", mv_cyc[i], first + i * PERIOD);
      check("pulse_byte", mv_byte[i], tx[i]);
      check("pulse_counter", mv_cnt[i], n);
    end
  endtask

  // Called in the last byte cycle; raises hash_ready delay cycles into WAIT_DIG.
  task automatic core_reply(input logic [31:0] dig, input int delay, input int n);
    tick();
    for (int i = 0; i < delay; i++) tick();
    check("counter_wait", m_counter, n);
    check("digest_early", dv_cnt, 0);
    hash_ready = 1'b1;
    digest_in  = dig;
    tick();
    digest_in = ~dig;
    check("d_valid_rise", d_valid, 1'b1);
    check("d_digest", d_digest, dig);
  endtask

  task automatic drain(input logic [31:0] dig, input int hold);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("d_valid_hold", d_valid, 1'b1);
      check("d_digest_hold", d_digest, dig);
      check("s_ready_busy", s_ready, 1'b0);
    end
    d_ready = 1'b1;
    tick();
    d_ready    = 1'b0;
    hash_ready = 1'b0;
    check("d_valid_clear", d_valid, 1'b0);
    check("s_ready_back", s_ready, 1'b1);
    check("counter_clear", m_counter, 0);
  endtask

  task automatic run_tx(input logic [31:0] dig, input int delay, input int hold, input bit allow_idle);
    int n_acc, last_acc, n, last;
    n = tx.size();
    clear_mon();
    host_send(1'b1, allow_idle, n_acc, last_acc);
    check("accepted", n_acc, n);
    last = last_acc + 1 + (n - 1) * PERIOD;
    check("schedule", cyc <= last, 1'b1);
    wait_until(last);
    check_pulses(n, last_acc + 1);
    core_reply(dig, delay, n);
    drain(dig, hold);
    check("pulse_count_final", mv_cyc.size(), n);
    check("no_overflow", ovf_cyc.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_acc, last_acc, last, first;
    logic [31:0] dig;

    // Reset values
    tick();
    tick();
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_message", m_message, 0);
    check("rst_m_counter", m_counter, 0);
    check("rst_d_valid", d_valid, 1'b0);
    check("rst_d_digest", d_digest, 0);
    check("rst_errs", {err_overflow, err_timeout}, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_s_ready", s_ready, 1'b1);

    // "abc" back-to-back
    tx = '{8'h61, 8'h62, 8'h63};
    run_tx(32'hDEADBEEF, 0, 0, 1'b0);

    // Single byte goes straight to WAIT_DIG
    tx = '{8'h41};
    run_tx(32'h12345678, 0, 1, 1'b0);

    // Overflow: no s_last, buffer fills
    make_msg(MAX_LEN + 2);
    clear_mon();
    host_send(1'b0, 1'b1, n_acc, last_acc);
    check("ovf_accepted", n_acc, MAX_LEN);
    last = last_acc + 1 + (MAX_LEN - 1) * PERIOD;
    check("ovf_schedule", cyc <= last, 1'b1);
    wait_until(last);
    check("ovf_count", ovf_cyc.size(), 1);
    if (ovf_cyc.size() > 0) check("ovf_cycle", ovf_cyc[0], last_acc + 1);
    check_pulses(MAX_LEN, last_acc + 1);
    dig = $urandom;
    core_reply(dig, 2, MAX_LEN);
    drain(dig, 0);

    // Timeout with hash_ready held low
    make_msg(3);
    clear_mon();
    host_send(1'b1, 1'b1, n_acc, last_acc);
    last = last_acc + 1 + 2 * PERIOD;
    wait_until(last);
    check_pulses(3, last_acc + 1);
    for (int i = 0; i < TIMEOUT + 10 && to_cyc.size() == 0; i++) tick();
    check("timeout_count", to_cyc.size(), 1);
    if (to_cyc.size() > 0) check("timeout_cycle", to_cyc[0], last + 1 + TIMEOUT);
    check("timeout_s_ready", s_ready, 1'b1);
    check("timeout_counter", m_counter, 0);
    tick();
    tick();
    check("timeout_single", to_cyc.size(), 1);
    check("timeout_no_digest", dv_cnt, 0);

    // Stale hash_ready high at WAIT_DIG entry, then re-rise
    hash_ready = 1'b1;
    digest_in  = 32'h0BAD0BAD;
    make_msg(4);
    clear_mon();
    host_send(1'b1, 1'b1, n_acc, last_acc);
    last = last_acc + 1 + 3 * PERIOD;
    wait_until(last);
    check_pulses(4, last_acc + 1);
    tick();
    tick();
    tick();
    check("stale_ignored", dv_cnt, 0);
    hash_ready = 1'b0;
    tick();
    dig        = 32'hC0FFEE01;
    hash_ready = 1'b1;
    digest_in  = dig;
    tick();
    digest_in = $urandom;
    check("rerise_d_valid", d_valid, 1'b1);
    check("rerise_d_digest", d_digest, dig);
    drain(dig, 10);

    // Asynchronous reset during GAP
    make_msg(5);
    clear_mon();
    host_send(1'b1, 1'b1, n_acc, last_acc);
    first = last_acc + 1;
    wait_until(first + PERIOD + 1);
    check("pre_rst_counter", m_counter, 5);
    rst_n = 1'b0;
    #1;
    check("async_m_valid", m_valid, 1'b0);
    check("async_counter", m_counter, 0);
    check("async_s_ready", s_ready, 1'b1);
    check("async_d_valid", d_valid, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_release_s_ready", s_ready, 1'b1);
    check("rst_release_m_valid", m_valid, 1'b0);
    make_msg(2);
    run_tx($urandom, 1, 2, 1'b1);

    // Random messages
    for (int k = 0; k < 6; k++) begin
      make_msg($urandom_range(1, MAX_LEN));
      run_tx($urandom, $urandom_range(0, 4), $urandom_range(0, 3), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
